// File: rtl/vga_capture_pkg.sv
// Shared definitions for the VGA frame capture peripheral: FSM states,
// register map, STATUS layout and ui_in bit positions.
package vga_capture_pkg;

    typedef enum logic [2:0] {
        ST_IDLE    = 3'd0,
        ST_WAIT_VS = 3'd1,
        ST_LINES   = 3'd2,
        ST_SAMPLE  = 3'd3,
        ST_DONE    = 3'd4
    } cap_state_t;

    localparam logic [5:0] ADDR_CTRL  = 6'h00;
    localparam logic [5:0] ADDR_H_OFF = 6'h04;
    localparam logic [5:0] ADDR_H_PER = 6'h08;
    localparam logic [5:0] ADDR_V_OFF = 6'h0C;
    localparam logic [5:0] ADDR_V_PER = 6'h10;

    localparam int CTRL_ARM     = 0;
    localparam int CTRL_CONT    = 1;
    localparam int CTRL_IRQ_EN  = 2;
    localparam int CTRL_IRQ_CLR = 7;

    localparam int STAT_BUSY = 0;
    localparam int STAT_DONE = 1;
    localparam int STAT_IRQ  = 2;
    localparam int STAT_ERR  = 3;

    localparam int UI_PIXEL = 4;
    localparam int UI_VSYNC = 5;
    localparam int UI_HSYNC = 6;

    localparam logic [1:0] XFER_8    = 2'b00;
    localparam logic [1:0] XFER_16   = 2'b01;
    localparam logic [1:0] XFER_32   = 2'b10;
    localparam logic [1:0] XFER_NONE = 2'b11;

    // Down-counter reload for a period register; a period of 0 acts as 1.
    function automatic logic [7:0] per_reload(input logic [7:0] per);
        return (per == 8'd0) ? 8'd0 : per - 8'd1;
    endfunction

endpackage

// File: rtl/vga_sync_edge.sv
// Edge detector for one sync line; reports transitions into and out of
// the asserted level, whichever polarity the source uses.
module vga_sync_edge #(
    parameter bit ACTIVE_LOW = 1'b1
) (
    input  logic clk,
    input  logic rst_n,
    input  logic sync,
    output logic assert_edge,
    output logic release_edge
);

    logic active_s;
    logic prev_active_r;

    assign active_s     = ACTIVE_LOW ? ~sync : sync;
    assign assert_edge  = active_s & ~prev_active_r;
    assign release_edge = ~active_s & prev_active_r;

    // Remember last cycle's asserted/not-asserted state.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            prev_active_r <= 1'b0;
        end else begin
            prev_active_r <= active_s;
        end
    end

endmodule

// File: rtl/vga_frame_capture.sv
// TinyQV peripheral that samples a 32x16 one-bit grid from a VGA-style
// hsync/vsync/pixel stream, with CPU-programmable cell timing.
module vga_frame_capture
    import vga_capture_pkg::*;
#(
    parameter bit SYNC_ACTIVE_LOW = 1'b1
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic [7:0]  ui_in,
    output logic [7:0]  uo_out,
    input  logic [5:0]  address,
    input  logic [31:0] data_in,
    input  logic [1:0]  data_write_n,
    input  logic [1:0]  data_read_n,
    output logic [31:0] data_out,
    output logic        data_ready,
    output logic        user_interrupt
);

    cap_state_t  state_r;
    logic        busy_r, done_r, err_r, irq_pending_r, cont_r, irq_en_r;
    logic [7:0]  h_off_r, h_per_r, v_off_r, v_per_r;
    logic [31:0] rows_r [16];
    logic [31:0] buf_r;
    logic [3:0]  row_idx_r;
    logic [4:0]  col_r;
    logic [9:0]  line_wait_r;
    logic [9:0]  clk_wait_r;
    logic [31:0] data_out_r;
    logic        data_ready_r;

    logic        hs_assert_s, hs_release_s, vs_assert_s, vs_release_s;
    logic        wr8_s, ctrl_wr_s, arm_wr_s, stop_wr_s, irq_clr_s, done_evt_s;
    logic        pixel_s, row_we_s;
    logic [31:0] new_buf_s, row_wdata_s;
    logic [7:0]  status_s;
    logic        unused_s;

    vga_sync_edge #(.ACTIVE_LOW(SYNC_ACTIVE_LOW)) u_hsync_edge (
        .clk          (clk),
        .rst_n        (rst_n),
        .sync         (ui_in[UI_HSYNC]),
        .assert_edge  (hs_assert_s),
        .release_edge (hs_release_s)
    );

    vga_sync_edge #(.ACTIVE_LOW(SYNC_ACTIVE_LOW)) u_vsync_edge (
        .clk          (clk),
        .rst_n        (rst_n),
        .sync         (ui_in[UI_VSYNC]),
        .assert_edge  (vs_assert_s),
        .release_edge (vs_release_s)
    );

    assign pixel_s    = ui_in[UI_PIXEL];
    assign wr8_s      = (data_write_n == XFER_8);
    assign ctrl_wr_s  = wr8_s && (address == ADDR_CTRL);
    assign arm_wr_s   = ctrl_wr_s && data_in[CTRL_ARM];
    assign stop_wr_s  = ctrl_wr_s && !data_in[CTRL_ARM] && busy_r;
    assign irq_clr_s  = ctrl_wr_s && data_in[CTRL_IRQ_CLR];
    // A CPU arm/stop in the DONE cycle pre-empts frame completion.
    assign done_evt_s = (state_r == ST_DONE) && !arm_wr_s && !stop_wr_s;
    assign new_buf_s  = buf_r | ({31'd0, pixel_s} << col_r);

    assign uo_out         = 8'd0;
    assign data_out       = data_out_r;
    assign data_ready     = data_ready_r;
    assign user_interrupt = irq_pending_r;
    assign unused_s       = &{1'b0, vs_release_s, ui_in[7], ui_in[3:0], data_in[31:8], data_in[6:3]};

    // STATUS byte assembly.
    always_comb begin
        status_s            = 8'd0;
        status_s[STAT_BUSY] = busy_r;
        status_s[STAT_DONE] = done_r;
        status_s[STAT_IRQ]  = irq_pending_r;
        status_s[STAT_ERR]  = err_r;
    end

    // Row commit: either the 32nd sample or an early hsync truncating the line.
    always_comb begin
        row_we_s    = 1'b0;
        row_wdata_s = buf_r;
        if (state_r == ST_SAMPLE && !arm_wr_s && !stop_wr_s && !vs_assert_s) begin
            if (hs_assert_s) begin
                row_we_s    = 1'b1;
                row_wdata_s = buf_r;
            end else if (clk_wait_r == 10'd0 && col_r == 5'd31) begin
                row_we_s    = 1'b1;
                row_wdata_s = new_buf_s;
            end else begin
                row_we_s    = 1'b0;
            end
        end else begin
            row_we_s = 1'b0;
        end
    end

    // Configuration registers, written with 8-bit stores only.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            cont_r   <= 1'b0;
            irq_en_r <= 1'b0;
            h_off_r  <= 8'd0;
            h_per_r  <= 8'd1;
            v_off_r  <= 8'd0;
            v_per_r  <= 8'd1;
        end else if (wr8_s) begin
            case (address)
                ADDR_CTRL: begin
                    cont_r   <= data_in[CTRL_CONT];
                    irq_en_r <= data_in[CTRL_IRQ_EN];
                end
                ADDR_H_OFF: h_off_r <= data_in[7:0];
                ADDR_H_PER: h_per_r <= data_in[7:0];
                ADDR_V_OFF: v_off_r <= data_in[7:0];
                ADDR_V_PER: v_per_r <= data_in[7:0];
                default: ;
            endcase
        end
    end

    // Capture FSM; CPU arm/stop writes take priority over stream events.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_r     <= ST_IDLE;
            busy_r      <= 1'b0;
            done_r      <= 1'b0;
            err_r       <= 1'b0;
            row_idx_r   <= 4'd0;
            col_r       <= 5'd0;
            line_wait_r <= 10'd0;
            clk_wait_r  <= 10'd0;
            buf_r       <= 32'd0;
        end else if (arm_wr_s) begin
            state_r <= ST_WAIT_VS;
            busy_r  <= 1'b1;
            done_r  <= 1'b0;
            err_r   <= 1'b0;
        end else if (stop_wr_s) begin
            state_r <= ST_IDLE;
            busy_r  <= 1'b0;
        end else begin
            case (state_r)
                ST_IDLE: state_r <= ST_IDLE;
                ST_WAIT_VS: begin
                    if (vs_assert_s) begin
                        state_r     <= ST_LINES;
                        row_idx_r   <= 4'd0;
                        line_wait_r <= {2'b00, v_off_r};
                    end
                end
                ST_LINES: begin
                    if (vs_assert_s) begin
                        err_r       <= 1'b1;
                        row_idx_r   <= 4'd0;
                        line_wait_r <= {2'b00, v_off_r};
                    end else if (hs_release_s) begin
                        if (line_wait_r == 10'd0) begin
                            state_r    <= ST_SAMPLE;
                            col_r      <= 5'd0;
                            clk_wait_r <= {2'b00, h_off_r};
                            buf_r      <= 32'd0;
                        end else begin
                            line_wait_r <= line_wait_r - 10'd1;
                        end
                    end
                end
                ST_SAMPLE: begin
                    if (vs_assert_s) begin
                        state_r     <= ST_LINES;
                        err_r       <= 1'b1;
                        row_idx_r   <= 4'd0;
                        line_wait_r <= {2'b00, v_off_r};
                    end else if (row_we_s) begin
                        if (hs_assert_s) begin
                            err_r <= 1'b1;
                        end
                        row_idx_r   <= row_idx_r + 4'd1;
                        line_wait_r <= {2'b00, per_reload(v_per_r)};
                        state_r     <= (row_idx_r == 4'd15) ? ST_DONE : ST_LINES;
                    end else if (clk_wait_r == 10'd0) begin
                        buf_r      <= new_buf_s;
                        col_r      <= col_r + 5'd1;
                        clk_wait_r <= {2'b00, per_reload(h_per_r)};
                    end else begin
                        clk_wait_r <= clk_wait_r - 10'd1;
                    end
                end
                ST_DONE: begin
                    done_r  <= 1'b1;
                    busy_r  <= 1'b0;
                    state_r <= cont_r ? ST_WAIT_VS : ST_IDLE;
                end
                default: state_r <= ST_IDLE;
            endcase
        end
    end

    // Interrupt flag: completion sets, IRQ_CLR clears, set wins on collision.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            irq_pending_r <= 1'b0;
        end else if (done_evt_s && irq_en_r) begin
            irq_pending_r <= 1'b1;
        end else if (irq_clr_s) begin
            irq_pending_r <= 1'b0;
        end
    end

    // Captured row storage.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            for (int i = 0; i < 16; i++) begin
                rows_r[i] <= 32'd0;
            end
        end else if (row_we_s) begin
            rows_r[row_idx_r] <= row_wdata_s;
        end
    end

    // Read port: one-cycle ready pulse the clock after a request.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            data_out_r   <= 32'd0;
            data_ready_r <= 1'b0;
        end else if (data_read_n != XFER_NONE && !data_ready_r) begin
            data_ready_r <= 1'b1;
            case (data_read_n)
                XFER_8:  data_out_r <= {24'd0, status_s};
                XFER_16: data_out_r <= 32'd0;
                XFER_32: data_out_r <= (address[1:0] == 2'b00) ? rows_r[address[5:2]] : 32'd0;
                default: data_out_r <= 32'd0;
            endcase
        end else begin
            data_ready_r <= 1'b0;
            data_out_r   <= 32'd0;
        end
    end

endmodule

// File: tb/tb_vga_frame_capture.sv
// Directed bench for vga_frame_capture: reset state, table of single-frame
// scenarios, then continuous mode, frame abort and re-arm sequences.
module tb_vga_frame_capture;

    logic        clk;
    logic        rst_n;
    logic [7:0]  ui_in;
    logic [7:0]  uo_out;
    logic [5:0]  address;
    logic [31:0] data_in;
    logic [1:0]  data_write_n;
    logic [1:0]  data_read_n;
    logic [31:0] data_out;
    logic        data_ready;
    logic        user_interrupt;

    int checks = 0;
    int errors = 0;

    vga_frame_capture #(.SYNC_ACTIVE_LOW(1'b1)) dut (
        .clk            (clk),
        .rst_n          (rst_n),
        .ui_in          (ui_in),
        .uo_out         (uo_out),
        .address        (address),
        .data_in        (data_in),
        .data_write_n   (data_write_n),
        .data_read_n    (data_read_n),
        .data_out       (data_out),
        .data_ready     (data_ready),
        .user_interrupt (user_interrupt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [7:0]  h_off;
        logic [7:0]  h_per;
        logic [7:0]  v_off;
        logic [7:0]  v_per;
        logic [7:0]  ctrl;
        int          period;
        int          nlines;
        bit          inv;
        logic [31:0] exp_row;
        logic [7:0]  exp_stat;
        logic        exp_irq;
    } scen_t;

    scen_t scen [4];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic bus_write8(input logic [5:0] a, input logic [7:0] d);
        @(negedge clk);
        address      = a;
        data_in      = {24'd0, d};
        data_write_n = 2'b00;
        @(negedge clk);
        data_write_n = 2'b11;
    endtask

    task automatic read_check(input string name, input logic [5:0] a, input logic [1:0] rn,
                              input logic [31:0] exp);
        @(negedge clk);
        address     = a;
        data_read_n = rn;
        @(negedge clk);
        check({name, "_ready"}, {31'd0, data_ready}, 32'd1);
        check(name, data_out, exp);
        data_read_n = 2'b11;
    endtask

    task automatic configure(input logic [7:0] ho, input logic [7:0] hp,
                             input logic [7:0] vo, input logic [7:0] vp);
        bus_write8(6'h04, ho);
        bus_write8(6'h08, hp);
        bus_write8(6'h0C, vo);
        bus_write8(6'h10, vp);
    endtask

    // Active-low syncs: hsync low for the first 10 clocks of each line,
    // vsync low for the first 2 lines. Pixel = column parity (optionally inverted).
    task automatic run_frame(input int nlines, input int period, input int hoff,
                             input int hper, input bit inv);
        int  pe;
        int  j;
        logic hs, vs, pix;
        pe = (hper == 0) ? 1 : hper;
        for (int l = 0; l < nlines; l++) begin
            for (int pos = 0; pos < period; pos++) begin
                @(negedge clk);
                hs = (pos < 10) ? 1'b0 : 1'b1;
                vs = (l < 2) ? 1'b0 : 1'b1;
                j  = pos - 10;
                if (j >= 1 + hoff) pix = ((((j - 1 - hoff) / pe) % 2) == 1) ^ inv;
                else               pix = 1'b0;
                ui_in = {1'b0, hs, vs, pix, 4'b0000};
            end
        end
        @(negedge clk);
        ui_in = 8'h60;
    endtask

    initial begin
        scen[0] = '{8'd4,  8'd2, 8'd3, 8'd4, 8'h05, 100, 70, 1'b0, 32'hAAAA_AAAA, 8'h06, 1'b1};
        scen[1] = '{8'd4,  8'd2, 8'd3, 8'd4, 8'h01, 40,  70, 1'b0, 32'h0000_0AAA, 8'h0A, 1'b0};
        scen[2] = '{8'd0,  8'd0, 8'd2, 8'd0, 8'h01, 100, 20, 1'b0, 32'hAAAA_AAAA, 8'h02, 1'b0};
        scen[3] = '{8'd10, 8'd2, 8'd0, 8'd1, 8'h05, 100, 20, 1'b1, 32'h5555_5555, 8'h06, 1'b1};

        rst_n        = 1'b0;
        ui_in        = 8'h60;
        address      = 6'd0;
        data_in      = 32'd0;
        data_write_n = 2'b11;
        data_read_n  = 2'b11;
        repeat (3) @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;

        // Reset state
        check("rst_uo_out", {24'd0, uo_out}, 32'd0);
        check("rst_irq", {31'd0, user_interrupt}, 32'd0);
        check("rst_ready", {31'd0, data_ready}, 32'd0);
        check("rst_data_out", data_out, 32'd0);
        read_check("rst_status", 6'h00, 2'b00, 32'h0000_0000);
        @(negedge clk);
        check("ready_one_cycle", {31'd0, data_ready}, 32'd0);
        read_check("rst_row5", 6'h14, 2'b10, 32'd0);
        read_check("rd16_zero", 6'h00, 2'b01, 32'd0);

        // Table of single-frame scenarios
        for (int i = 0; i < 4; i++) begin
            configure(scen[i].h_off, scen[i].h_per, scen[i].v_off, scen[i].v_per);
            bus_write8(6'h00, scen[i].ctrl);
            run_frame(scen[i].nlines, scen[i].period, int'(scen[i].h_off),
                      int'(scen[i].h_per), scen[i].inv);
            read_check($sformatf("s%0d_row0", i),  6'h00, 2'b10, scen[i].exp_row);
            read_check($sformatf("s%0d_row7", i),  6'h1C, 2'b10, scen[i].exp_row);
            read_check($sformatf("s%0d_row15", i), 6'h3C, 2'b10, scen[i].exp_row);
            read_check($sformatf("s%0d_status", i), 6'h00, 2'b00, {24'd0, scen[i].exp_stat});
            check($sformatf("s%0d_irq", i), {31'd0, user_interrupt}, {31'd0, scen[i].exp_irq});
            bus_write8(6'h00, 8'h80);
            @(negedge clk);
            check($sformatf("s%0d_irq_clr", i), {31'd0, user_interrupt}, 32'd0);
        end

        // Continuous mode over two frames, pattern inverted in the second
        configure(8'd4, 8'd2, 8'd3, 8'd4);
        bus_write8(6'h00, 8'h07);
        run_frame(70, 100, 4, 2, 1'b0);
        read_check("cont_f1_row3", 6'h0C, 2'b10, 32'hAAAA_AAAA);
        check("cont_f1_irq", {31'd0, user_interrupt}, 32'd1);
        bus_write8(6'h00, 8'h86);
        @(negedge clk);
        check("cont_irq_clr", {31'd0, user_interrupt}, 32'd0);
        run_frame(70, 100, 4, 2, 1'b1);
        read_check("cont_f2_row3", 6'h0C, 2'b10, 32'h5555_5555);
        check("cont_f2_irq", {31'd0, user_interrupt}, 32'd1);
        read_check("cont_f2_status", 6'h00, 2'b00, 32'h0000_0006);
        bus_write8(6'h00, 8'h80);

        // Short frame aborted by an early vsync, then a full frame
        bus_write8(6'h00, 8'h01);
        run_frame(20, 100, 4, 2, 1'b0);
        read_check("abort_row4", 6'h10, 2'b10, 32'hAAAA_AAAA);
        read_check("abort_row5_kept", 6'h14, 2'b10, 32'h5555_5555);
        read_check("abort_status_mid", 6'h00, 2'b00, 32'h0000_0001);
        run_frame(70, 100, 4, 2, 1'b1);
        read_check("abort_row4_final", 6'h10, 2'b10, 32'h5555_5555);
        read_check("abort_status_final", 6'h00, 2'b00, 32'h0000_000A);

        // Re-arm while sampling row 0: rest of that frame must not be captured
        bus_write8(6'h00, 8'h01);
        fork
            run_frame(20, 100, 4, 2, 1'b0);
            begin
                repeat (330) @(negedge clk);
                bus_write8(6'h00, 8'h01);
            end
        join
        read_check("rearm_row1_kept", 6'h04, 2'b10, 32'h5555_5555);
        read_check("rearm_status_busy", 6'h00, 2'b00, 32'h0000_0001);
        run_frame(70, 100, 4, 2, 1'b0);
        read_check("rearm_row1_final", 6'h04, 2'b10, 32'hAAAA_AAAA);
        read_check("rearm_status_final", 6'h00, 2'b00, 32'h0000_0002);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
